// File: rtl/if_stage.sv
// if_stage: instruction-fetch stage holding the PC, driving imem_addr and loading the IF/ID register.
//   clk, rst_n                   : clock, asynchronous active-low reset
//   PCsrc, flush, stall          : next-PC select (00 +2, 01 branch, 10 jump, 11 hold), squash, hold
//   branch_target, jump_target   : redirect destinations from decode
//   imem_addr / imem_data        : instruction memory address (= PC) and combinational read data
//   if_id_instr, if_id_pcplus2,
//   if_id_valid                  : IF/ID pipeline register
//   halted, fetch_count          : halt freeze flag, saturating count of valid fetches
module if_stage #(
  parameter int ADDR_W = 16,
  parameter int INSTR_W = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter logic [INSTR_W-1:0] BUBBLE = 16'hF000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [1:0]         PCsrc,
  input  logic               flush,
  input  logic               stall,
  input  logic [ADDR_W-1:0]  branch_target,
  input  logic [ADDR_W-1:0]  jump_target,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_data,
  output logic [INSTR_W-1:0] if_id_instr,
  output logic [ADDR_W-1:0]  if_id_pcplus2,
  output logic               if_id_valid,
  output logic               halted,
  output logic [15:0]        fetch_count
);
  logic [ADDR_W-1:0] pc, pc_plus2, pc_sel;
  logic halt_hit;
  assign imem_addr = pc;
  assign pc_plus2 = pc + ADDR_W'(2);
  // targets are forced halfword aligned
  always_comb pc_sel = PCsrc == 2'b00 ? pc_plus2 :
                       PCsrc == 2'b01 ? {branch_target[ADDR_W-1:1], 1'b0} :
                       PCsrc == 2'b10 ? {jump_target[ADDR_W-1:1], 1'b0} : pc;
  // a halt opcode in IF/ID freezes fetch unless decode is squashing it
  assign halt_hit = if_id_valid && if_id_instr[INSTR_W-1 -: 4] == 4'h0 && !flush;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc <= RESET_PC;
      if_id_instr <= BUBBLE;
      if_id_pcplus2 <= '0;
      if_id_valid <= 1'b0;
      halted <= 1'b0;
      fetch_count <= '0;
    end else if (halted) begin
      if_id_valid <= 1'b0;
    end else if (halt_hit) begin
      halted <= 1'b1;
      if_id_instr <= BUBBLE;
      if_id_valid <= 1'b0;
    end else if (flush) begin
      pc <= pc_sel;
      if_id_instr <= BUBBLE;
      if_id_pcplus2 <= pc_plus2;
      if_id_valid <= 1'b0;
    end else if (!stall) begin
      pc <= pc_sel;
      if_id_instr <= imem_data;
      if_id_pcplus2 <= pc_plus2;
      if_id_valid <= 1'b1;
      if (fetch_count != 16'hFFFF) fetch_count <= fetch_count + 16'd1;
    end
  end
endmodule

// File: tb/tb_if_stage.sv
// tb_if_stage: randomized self-checking bench for if_stage against a behavioural fetch model.
module tb_if_stage;
  logic clk = 1'b0, rst_n = 1'b0, flush = 1'b0, stall = 1'b0;
  logic [1:0] PCsrc = 2'b00;
  logic [15:0] branch_target = '0, jump_target = '0, imem_addr, imem_data;
  logic [15:0] if_id_instr, if_id_pcplus2, fetch_count;
  logic if_id_valid, halted;
  logic [15:0] mem [0:32767];
  logic [15:0] m_pc, m_instr, m_pc2, m_count;
  logic m_valid, m_halted;
  logic [65:0] obs;
  int passed = 0, total = 0;

  if_stage dut (.clk(clk), .rst_n(rst_n), .PCsrc(PCsrc), .flush(flush), .stall(stall),
    .branch_target(branch_target), .jump_target(jump_target), .imem_addr(imem_addr),
    .imem_data(imem_data), .if_id_instr(if_id_instr), .if_id_pcplus2(if_id_pcplus2),
    .if_id_valid(if_id_valid), .halted(halted), .fetch_count(fetch_count));

  always #5 clk = ~clk;
  assign imem_data = mem[imem_addr[15:1]];
  assign obs = {imem_addr, if_id_instr, if_id_pcplus2, if_id_valid, halted, fetch_count};

  function automatic logic [65:0] exp_vec();
    return {m_pc, m_instr, m_pc2, m_valid, m_halted, m_count};
  endfunction

  task automatic fill_mem(input int halt_pct);
    for (int i = 0; i < 32768; i++) begin
      logic [15:0] w;
      w = 16'($urandom);
      if (int'($urandom_range(99)) < halt_pct) w[15:12] = 4'h0;
      else if (w[15:12] == 4'h0) w[15:12] = 4'h1;
      mem[i] = w;
    end
  endtask

  task automatic model_reset();
    m_pc = 16'h0000; m_instr = 16'hF000; m_pc2 = 16'h0000;
    m_valid = 1'b0; m_halted = 1'b0; m_count = 16'h0000;
  endtask

  // reference behaviour for one rising edge with the inputs currently driven
  task automatic step();
    logic [15:0] target;
    case (PCsrc)
      2'b00: target = m_pc + 16'd2;
      2'b01: target = branch_target & 16'hFFFE;
      2'b10: target = jump_target & 16'hFFFE;
      default: target = m_pc;
    endcase
    if (m_halted) m_valid = 1'b0;
    else if (m_valid && m_instr[15:12] == 4'h0 && !flush) begin
      m_halted = 1'b1; m_instr = 16'hF000; m_valid = 1'b0;
    end else if (flush) begin
      m_pc2 = m_pc + 16'd2; m_pc = target; m_instr = 16'hF000; m_valid = 1'b0;
    end else if (!stall) begin
      m_instr = mem[m_pc[15:1]]; m_pc2 = m_pc + 16'd2; m_pc = target; m_valid = 1'b1;
      if (m_count != 16'hFFFF) m_count = m_count + 16'd1;
    end
  endtask

  task automatic edge_step();
    step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] s, input logic f, input logic st);
    PCsrc = s; flush = f; stall = st;
  endtask

  task automatic do_reset();
    #2 rst_n = 1'b0;
    drive(2'b00, 1'b0, 1'b0);
    model_reset();
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_reset();
    fill_mem(0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    edge_step();
    edge_step();
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    total++;
    if (obs !== 66'({16'h0000, 16'hF000, 16'h0000, 1'b0, 1'b0, 16'h0000}))
      $display("FAIL reset_async: got %h expected %h", obs, exp_vec());
    else passed++;
    @(posedge clk); #1 rst_n = 1'b1;
  endtask

  task automatic test_straight();
    logic [15:0] words [4];
    fill_mem(0);
    do_reset();
    words[0] = 16'h1234; words[1] = 16'h2BCD; words[2] = 16'hF00F; words[3] = 16'hA5A5;
    for (int i = 0; i < 4; i++) mem[i] = words[i];
    for (int i = 0; i < 4; i++) begin
      total++;
      if (imem_addr !== 16'(2 * i)) $display("FAIL straight_addr%0d: got %h expected %h", i, imem_addr, 16'(2 * i));
      else passed++;
      edge_step();
      total++;
      if ({if_id_instr, if_id_pcplus2, if_id_valid, fetch_count} !== {words[i], 16'(2 * i + 2), 1'b1, 16'(i + 1)})
        $display("FAIL straight_ifid%0d: got %h/%h/%b/%0d expected %h/%h/1/%0d", i,
          if_id_instr, if_id_pcplus2, if_id_valid, fetch_count, words[i], 16'(2 * i + 2), i + 1);
      else passed++;
    end
  endtask

  task automatic test_branch();
    fill_mem(0);
    do_reset();
    edge_step();
    edge_step();
    branch_target = 16'h0021;
    drive(2'b01, 1'b1, 1'b0);
    edge_step();
    total++;
    if ({imem_addr, if_id_instr, if_id_valid, fetch_count} !== {16'h0020, 16'hF000, 1'b0, 16'd2})
      $display("FAIL branch_redirect: got %h/%h/%b/%0d expected 0020/f000/0/2", imem_addr, if_id_instr, if_id_valid, fetch_count);
    else passed++;
    drive(2'b00, 1'b0, 1'b0);
    edge_step();
    total++;
    if (obs !== exp_vec() || if_id_instr !== mem[16'h0010]) $display("FAIL branch_target_fetch: got %h expected %h", obs, exp_vec());
    else passed++;
  endtask

  task automatic test_stall_flush();
    logic [65:0] held;
    fill_mem(0);
    do_reset();
    edge_step();
    edge_step();
    held = obs;
    for (int i = 0; i < 2; i++) begin
      drive(2'($urandom), 1'b0, 1'b1);
      edge_step();
      total++;
      if (obs !== held || obs !== exp_vec()) $display("FAIL stall_hold%0d: got %h expected %h", i, obs, held);
      else passed++;
    end
    jump_target = 16'h0040;
    drive(2'b10, 1'b1, 1'b1);
    edge_step();
    total++;
    if ({imem_addr, if_id_instr, if_id_pcplus2, if_id_valid} !== {16'h0040, 16'hF000, 16'h0006, 1'b0})
      $display("FAIL stall_flush_jump: got %h expected %h", obs, exp_vec());
    else passed++;
  endtask

  task automatic test_halt();
    logic [65:0] frozen;
    fill_mem(0);
    mem[4] = 16'h0000;
    do_reset();
    for (int i = 0; i < 5; i++) edge_step();
    total++;
    if (if_id_instr !== 16'h0000 || if_id_valid !== 1'b1 || halted !== 1'b0)
      $display("FAIL halt_visible: got %h/%b/%b expected 0000/1/0", if_id_instr, if_id_valid, halted);
    else passed++;
    edge_step();
    total++;
    if ({halted, imem_addr, if_id_valid, if_id_instr} !== {1'b1, 16'h000A, 1'b0, 16'hF000})
      $display("FAIL halt_set: got %b/%h/%b/%h expected 1/000a/0/f000", halted, imem_addr, if_id_valid, if_id_instr);
    else passed++;
    frozen = obs;
    for (int i = 0; i < 10; i++) begin
      drive(2'($urandom), 1'($urandom), 1'($urandom));
      branch_target = 16'($urandom); jump_target = 16'($urandom);
      edge_step();
      total++;
      if (obs !== frozen || obs !== exp_vec()) $display("FAIL halt_frozen%0d: got %h expected %h", i, obs, frozen);
      else passed++;
    end
  endtask

  task automatic test_flushed_halt();
    fill_mem(0);
    mem[0] = 16'h0123;
    do_reset();
    edge_step();
    jump_target = 16'h0030;
    drive(2'b10, 1'b1, 1'b0);
    edge_step();
    total++;
    if ({halted, imem_addr, if_id_valid} !== {1'b0, 16'h0030, 1'b0})
      $display("FAIL flushed_halt: got %b/%h/%b expected 0/0030/0", halted, imem_addr, if_id_valid);
    else passed++;
    drive(2'b00, 1'b0, 1'b0);
    edge_step();
    total++;
    if (obs !== exp_vec() || if_id_instr !== mem[16'h0018] || halted !== 1'b0)
      $display("FAIL flushed_halt_resume: got %h expected %h", obs, exp_vec());
    else passed++;
  endtask

  task automatic test_wrap_reset();
    fill_mem(0);
    do_reset();
    jump_target = 16'hFFFF;
    drive(2'b10, 1'b1, 1'b0);
    edge_step();
    drive(2'b00, 1'b0, 1'b0);
    edge_step();
    total++;
    if ({imem_addr, if_id_pcplus2, if_id_instr} !== {16'h0000, 16'h0000, mem[16'h7FFF]})
      $display("FAIL wrap: got %h/%h expected 0000/0000", imem_addr, if_id_pcplus2);
    else passed++;
    edge_step();
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    total++;
    if (obs !== exp_vec()) $display("FAIL reset_midrun: got %h expected %h", obs, exp_vec());
    else passed++;
    @(posedge clk); #1 rst_n = 1'b1;
    edge_step();
    total++;
    if (obs !== exp_vec() || if_id_instr !== mem[0]) $display("FAIL reset_first_fetch: got %h expected %h", obs, exp_vec());
    else passed++;
  endtask

  task automatic test_random();
    int bad = 0;
    fill_mem(3);
    do_reset();
    for (int i = 0; i < 600; i++) begin
      if (m_halted && $urandom_range(3) == 0) do_reset();
      drive(2'($urandom), $urandom_range(3) == 0, $urandom_range(3) == 0);
      branch_target = 16'($urandom); jump_target = 16'($urandom);
      edge_step();
      total++;
      if (obs !== exp_vec()) begin
        if (bad < 5) $display("FAIL random%0d: got %h expected %h", i, obs, exp_vec());
        bad++;
      end else passed++;
    end
  endtask

  task automatic test_saturate();
    fill_mem(0);
    do_reset();
    for (int i = 0; i < 65534; i++) edge_step();
    total++;
    if (fetch_count !== 16'hFFFE || obs !== exp_vec()) $display("FAIL count_near_sat: got %h expected fffe", fetch_count);
    else passed++;
    for (int i = 0; i < 3; i++) edge_step();
    total++;
    if (fetch_count !== 16'hFFFF || obs !== exp_vec()) $display("FAIL count_sat: got %h expected ffff", fetch_count);
    else passed++;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_straight();
    test_branch();
    test_stall_flush();
    test_halt();
    test_flushed_halt();
    test_wrap_reset();
    test_random();
    test_saturate();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/if_stage.md
# if_stage

Instruction-fetch stage of the pipelined CPU: holds the program counter, drives instruction-memory address, and loads the IF/ID pipeline register. Sits directly upstream of the decode/control stage. Consumes that stage's `PCsrc` and `flush` outputs to redirect fetch, and consumes `stall` from the hazard unit. Detects the halt opcode (4'h0) in IF/ID and freezes fetch.

## Interface
Parameters:
- `ADDR_W`, 16, PC / address width.
- `INSTR_W`, 16, instruction width; opcode is `[INSTR_W-1:INSTR_W-4]`.
- `RESET_PC`, 16'h0000, PC value after reset.
- `BUBBLE`, 16'hF000, instruction word placed in IF/ID for a bubble.

Ports:
- `clk`  in  1  clock; all state updates on rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `PCsrc`  in  2  next-PC select: 00 PC+2, 01 `branch_target`, 10 `jump_target`, 11 hold.
- `flush`  in  1  squash the instruction entering IF/ID this edge.
- `stall`  in  1  hold PC and IF/ID (load-use hazard).
- `branch_target`  in  ADDR_W  branch destination from decode.
- `jump_target`  in  ADDR_W  jump destination from decode.
- `imem_addr`  out  ADDR_W  = PC, combinational.
- `imem_data`  in  INSTR_W  combinational instruction read at `imem_addr`.
- `if_id_instr`  out  INSTR_W  registered instruction to decode.
- `if_id_pcplus2`  out  ADDR_W  registered PC+2 of that instruction.
- `if_id_valid`  out  1  IF/ID holds a real instruction.
- `halted`  out  1  fetch frozen by halt.
- `fetch_count`  out  16  valid instructions loaded into IF/ID, saturating at 16'hFFFF.

## Operation
- Next PC selection:
  - 00 → PC+2, modulo 2^ADDR_W, so 0xFFFE wraps to 0x0000.
  - 01 / 10 → selected target with bit 0 forced to 0.
  - 11 → PC unchanged.
- Priority per edge, highest first:
  1. reset
  2. `halted`
  3. `flush`
  4. `stall`
  5. normal
- `halted`=1: PC, IF/ID, and `fetch_count` hold; `if_id_valid`=0; all inputs ignored. Only reset clears `halted`.
- `flush`=1: PC loads the PCsrc selection even if `stall`=1. IF/ID loads `BUBBLE`, valid=0, pcplus2 = PC+2 of the squashed fetch. No count increment.
- `stall`=1, `flush`=0: PC and all IF/ID outputs hold; no count increment.
- Normal:
  - PC loads the PCsrc selection.
  - IF/ID loads `imem_data` and PC+2, valid=1.
  - `fetch_count` increments unless already 0xFFFF.
- Halt detect: when `if_id_valid`=1, opcode of `if_id_instr`=4'h0, and `flush`=0, `halted` sets on that edge.
  - On the same edge, IF/ID becomes a bubble (valid=0, instr=`BUBBLE`), and PC keeps its current value.
  - A halt that is flushed never sets `halted`.

## Timing
- Reset values (asynchronous, immediate on `rst_n` low):
  - PC=`RESET_PC`, `imem_addr`=`RESET_PC`.
  - `if_id_instr`=`BUBBLE`, `if_id_pcplus2`=0, `if_id_valid`=0.
  - `halted`=0, `fetch_count`=0.
- Reset deassertion mid-operation: the first fetch is from `RESET_PC` on the first rising edge after `rst_n` goes high. No partial state survives.
- Fetch latency: the instruction at PC appears on `if_id_instr` one edge after PC is presented on `imem_addr`.
- Redirect: `PCsrc`/`flush` sampled at edge N, so the target is on `imem_addr` after edge N and its instruction is in IF/ID after edge N+1. Exactly one bubble per taken branch or jump.
- Stall: every cycle `stall` is high at the edge extends the IF/ID contents by one cycle. No instruction is lost or duplicated.
- Halt: `halted` rises one edge after the halt instruction enters IF/ID. The halt instruction is visible to decode for exactly one cycle.
- `imem_addr` is purely a function of the PC register; it has no combinational path from any input.

## Test plan
- Reset, then run straight-line code: memory 0x0000–0x0006 holds 1xxx, 2xxx, Fxxx, Axxx, PCsrc=00 → `imem_addr` 0,2,4,6 on successive cycles; IF/ID valid from cycle 1; pcplus2 = 2,4,6,8; `fetch_count`=4 after 4 edges.
- Taken branch: at PC=0x0004, drive PCsrc=01, flush=1, branch_target=0x0021 for one edge → next `imem_addr`=0x0020; IF/ID = `BUBBLE`/valid=0 for one cycle; `fetch_count` not incremented for that edge.
- Stall vs. flush: stall=1 for 2 edges → PC and IF/ID unchanged for those 2 cycles. Then stall=1 with flush=1 and PCsrc=10, jump_target=0x0040 → PC=0x0040 and IF/ID is a bubble.
- Halt: memory word 0x0000 at 0x0008 → `halted`=1 one edge after it reaches IF/ID; PC holds 0x000A; valid=0; PCsrc/flush/stall toggles have no effect for 10 cycles.
- Flushed halt: halt opcode in IF/ID with flush=1 on the same edge → `halted` stays 0 and fetch continues at the redirect target.
- Wrap and reset mid-run: PC=0xFFFE with PCsrc=00 → next PC=0x0000. Asserting `rst_n`=0 between edges immediately forces all outputs to their reset values.
